// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_unit
// Brief    : RAW hazard detection, forwarding select, branch flush and
//            saturating stall/flush counters for the in-order pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_unit #(
    parameter int STAGES = 3,
    parameter int RA_W   = 4,
    parameter int FWD_EN = 0,
    parameter int CNT_W  = 16,
    parameter int SEL_W  = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_src1,
    input  logic [RA_W-1:0]  id_src2,
    input  logic             id_src1_use,
    input  logic             id_src2_use,
    input  logic [RA_W-1:0]  id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             branch_taken,
    output logic             hazard,
    output logic             freeze,
    output logic             flush,
    output logic             bubble,
    output logic [SEL_W-1:0] fwd_sel1,
    output logic [SEL_W-1:0] fwd_sel2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [STAGES:1]  r_v;
    logic [STAGES:1]  r_wb;
    logic [STAGES:1]  r_mr;
    logic [RA_W-1:0]  r_dest [1:STAGES];
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [STAGES:1]  w_m1;
    logic [STAGES:1]  w_m2;
    logic             w_haz_raw;
    logic [SEL_W-1:0] w_sel1_raw;
    logic [SEL_W-1:0] w_sel2_raw;
    logic             w_hazard;
    logic             w_freeze;
    logic             w_flush;
    logic             w_bubble;
    logic             w_unused;

    // The oldest entry's load flag is never consulted; it simply retires.
    assign w_unused = ^r_mr;

    generate
        for (genvar k = 1; k <= STAGES; k++) begin : g_match
            assign w_m1[k] = id_valid & id_src1_use & r_v[k] & r_wb[k] & (r_dest[k] == id_src1);
            assign w_m2[k] = id_valid & id_src2_use & r_v[k] & r_wb[k] & (r_dest[k] == id_src2);
        end
    endgenerate

    generate
        if (FWD_EN != 0) begin : g_fwd
            assign w_haz_raw = (w_m1[1] | w_m2[1]) & r_mr[1];

            // Scan oldest to youngest so the youngest producer overwrites.
            always_comb begin
                w_sel1_raw = '0;
                w_sel2_raw = '0;
                for (int k = STAGES; k >= 1; k--) begin
                    if (w_m1[k]) w_sel1_raw = SEL_W'(k);
                    if (w_m2[k]) w_sel2_raw = SEL_W'(k);
                end
            end
        end else begin : g_stall
            assign w_haz_raw  = |{w_m1, w_m2};
            assign w_sel1_raw = '0;
            assign w_sel2_raw = '0;
        end
    endgenerate

    // All control outputs are held inactive while reset is asserted.
    assign w_hazard = rst & w_haz_raw;
    assign w_flush  = rst & branch_taken;
    assign w_freeze = w_hazard & ~branch_taken;
    assign w_bubble = w_hazard | w_flush;

    assign hazard    = w_hazard;
    assign freeze    = w_freeze;
    assign flush     = w_flush;
    assign bubble    = w_bubble;
    assign fwd_sel1  = rst ? w_sel1_raw : '0;
    assign fwd_sel2  = rst ? w_sel2_raw : '0;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v  <= '0;
            r_wb <= '0;
            r_mr <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                r_dest[k] <= '0;
            end
        end else begin
            r_v[1]    <= id_valid & ~w_bubble;
            r_dest[1] <= id_dest;
            r_wb[1]   <= id_wb_en;
            r_mr[1]   <= id_mem_r_en;
            for (int k = 2; k <= STAGES; k++) begin
                r_v[k]    <= r_v[k-1];
                r_dest[k] <= r_dest[k-1];
                r_wb[k]   <= r_wb[k-1];
                r_mr[k]   <= r_mr[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_freeze && (r_stall_cnt != c_cnt_max)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush && (r_flush_cnt != c_cnt_max))  r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_unit
// Brief    : Scoreboard bench for pipe_hazard_unit in stall and forwarding modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_unit;

    typedef struct packed {
        logic       valid;
        logic [3:0] src1;
        logic       use1;
        logic [3:0] src2;
        logic       use2;
        logic [3:0] dest;
        logic       wb;
        logic       mr;
        logic       br;
    } in_t;

    typedef struct {
        string       name;
        bit          dut;
        logic [7:0]  flags;
        bit          chk;
        logic [15:0] scnt;
        logic [15:0] fcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    in_t  in_s = '0;
    in_t  in_f = '0;

    logic        s_haz, s_frz, s_fl, s_bub;
    logic [1:0]  s_sel1, s_sel2;
    logic [3:0]  s_scnt, s_fcnt;
    logic        f_haz, f_frz, f_fl, f_bub;
    logic [1:0]  f_sel1, f_sel2;
    logic [15:0] f_scnt, f_fcnt;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.STAGES(3), .RA_W(4), .FWD_EN(0), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst),
        .id_valid(in_s.valid), .id_src1(in_s.src1), .id_src2(in_s.src2),
        .id_src1_use(in_s.use1), .id_src2_use(in_s.use2),
        .id_dest(in_s.dest), .id_wb_en(in_s.wb), .id_mem_r_en(in_s.mr),
        .branch_taken(in_s.br),
        .hazard(s_haz), .freeze(s_frz), .flush(s_fl), .bubble(s_bub),
        .fwd_sel1(s_sel1), .fwd_sel2(s_sel2),
        .stall_cnt(s_scnt), .flush_cnt(s_fcnt)
    );

    pipe_hazard_unit #(.STAGES(3), .RA_W(4), .FWD_EN(1), .CNT_W(16)) dut_f (
        .clk(clk), .rst(rst),
        .id_valid(in_f.valid), .id_src1(in_f.src1), .id_src2(in_f.src2),
        .id_src1_use(in_f.use1), .id_src2_use(in_f.use2),
        .id_dest(in_f.dest), .id_wb_en(in_f.wb), .id_mem_r_en(in_f.mr),
        .branch_taken(in_f.br),
        .hazard(f_haz), .freeze(f_frz), .flush(f_fl), .bubble(f_bub),
        .fwd_sel1(f_sel1), .fwd_sel2(f_sel2),
        .stall_cnt(f_scnt), .flush_cnt(f_fcnt)
    );

    function automatic in_t mk(input logic v, input logic [3:0] s1, input logic u1,
                               input logic [3:0] s2, input logic u2, input logic [3:0] d,
                               input logic wb, input logic mr, input logic br);
        in_t r;
        r = '{v, s1, u1, s2, u2, d, wb, mr, br};
        return r;
    endfunction

    function automatic logic [7:0] fl8(input logic haz, input logic frz, input logic fl,
                                       input logic bub, input logic [1:0] s1, input logic [1:0] s2);
        return {haz, frz, fl, bub, s1, s2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit d, input string name, input logic [7:0] flags,
                        input bit chk, input logic [15:0] sc, input logic [15:0] fc);
        exp_t e;
        e.name = name; e.dut = d; e.flags = flags; e.chk = chk; e.scnt = sc; e.fcnt = fc;
        q.push_back(e);
    endtask

    task automatic cyc_s(input in_t v, input string name, input logic [7:0] flags,
                         input bit chk, input logic [15:0] sc, input logic [15:0] fc);
        in_s = v;
        in_f = '0;
        push(1'b0, name, flags, chk, sc, fc);
        tick();
    endtask

    task automatic cyc_f(input in_t v, input string name, input logic [7:0] flags,
                         input bit chk, input logic [15:0] sc, input logic [15:0] fc);
        in_f = v;
        in_s = '0;
        push(1'b1, name, flags, chk, sc, fc);
        tick();
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    exp_t        m_e;
    logic [7:0]  m_af;
    logic [15:0] m_sc, m_fc;
    always @(negedge clk) begin
        while (q.size() > 0) begin
            m_e = q.pop_front();
            if (!m_e.dut) begin
                m_af = {s_haz, s_frz, s_fl, s_bub, s_sel1, s_sel2};
                m_sc = {12'd0, s_scnt};
                m_fc = {12'd0, s_fcnt};
            end else begin
                m_af = {f_haz, f_frz, f_fl, f_bub, f_sel1, f_sel2};
                m_sc = f_scnt;
                m_fc = f_fcnt;
            end
            n_tests++;
            if ((m_af !== m_e.flags) || (m_e.chk && ((m_sc !== m_e.scnt) || (m_fc !== m_e.fcnt)))) begin
                n_fail++;
                $display("FAIL %s: got haz/frz/fl/bub/sel1/sel2=%b stall=%0d flush=%0d, expected %b stall=%0d flush=%0d",
                         m_e.name, m_af, m_sc, m_fc, m_e.flags, m_e.scnt, m_e.fcnt);
            end
        end
    end

    localparam logic [7:0] c_z    = 8'b0000_0000;
    localparam logic [7:0] c_stal = 8'b1101_0000;

    initial begin
        int sat_exp [6];
        sat_exp = '{6, 9, 12, 15, 15, 15};

        // Reset held with branch and valid active: everything must read 0.
        rst  = 1'b0;
        in_s = mk(1, 2, 1, 2, 1, 2, 1, 1, 1);
        in_f = in_s;
        tick();
        for (int i = 0; i < 2; i++) begin
            push(1'b0, "reset_s", c_z, 1'b1, 0, 0);
            push(1'b1, "reset_f", c_z, 1'b1, 0, 0);
            tick();
        end
        rst  = 1'b1;
        in_s = '0;
        in_f = '0;
        for (int i = 0; i < 3; i++) begin
            push(1'b0, "post_reset_s", c_z, 1'b1, 0, 0);
            push(1'b1, "post_reset_f", c_z, 1'b1, 0, 0);
            tick();
        end

        // Stall mode: back-to-back RAW gives a 3-cycle stall.
        cyc_s(mk(1, 0, 0, 0, 0, 2, 1, 0, 0), "st_prod", c_z, 1'b1, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc_s(mk(1, 2, 1, 0, 0, 3, 1, 0, 0), "st_stall", c_stal, 1'b1, 16'(i), 0);
        cyc_s(mk(1, 2, 1, 0, 0, 3, 1, 0, 0), "st_release", c_z, 1'b1, 3, 0);
        for (int i = 0; i < 3; i++) cyc_s('0, "st_idle", c_z, 1'b1, 3, 0);

        // Producer without write-back never matches.
        cyc_s(mk(1, 0, 0, 0, 0, 2, 0, 0, 0), "nowb_prod", c_z, 1'b1, 3, 0);
        cyc_s(mk(1, 2, 1, 0, 0, 3, 0, 0, 0), "nowb_dep", c_z, 1'b1, 3, 0);
        for (int i = 0; i < 3; i++) cyc_s('0, "nowb_idle", c_z, 1'b1, 3, 0);

        // Branch in the same cycle as a RAW hazard on src2.
        cyc_s(mk(1, 0, 0, 0, 0, 4, 1, 0, 0), "br_prod", c_z, 1'b1, 3, 0);
        cyc_s(mk(1, 0, 0, 4, 1, 6, 1, 0, 1), "br_haz", fl8(1, 0, 1, 1, 0, 0), 1'b1, 3, 0);
        cyc_s(mk(1, 6, 1, 0, 0, 0, 0, 0, 0), "br_after", c_z, 1'b1, 3, 1);
        for (int i = 0; i < 3; i++) cyc_s('0, "br_idle", c_z, 1'b1, 3, 1);

        // Saturation of the 4-bit stall counter.
        for (int p = 0; p < 6; p++) begin
            cyc_s(mk(1, 0, 0, 0, 0, 7, 1, 0, 0), "sat_prod", c_z, 1'b0, 0, 0);
            for (int i = 0; i < 3; i++)
                cyc_s(mk(1, 7, 1, 0, 0, 0, 0, 0, 0), "sat_stall", c_stal, 1'b0, 0, 0);
            cyc_s(mk(1, 7, 1, 0, 0, 0, 0, 0, 0), "sat_cnt", c_z, 1'b1, 16'(sat_exp[p]), 1);
        end
        for (int i = 0; i < 2; i++) cyc_s('0, "sat_hold", c_z, 1'b1, 15, 1);

        // Forwarding mode: ALU result forwarded from EXE.
        cyc_f(mk(1, 0, 0, 0, 0, 2, 1, 0, 0), "fw_prod", c_z, 1'b1, 0, 0);
        cyc_f(mk(1, 0, 0, 2, 1, 9, 0, 0, 0), "fw_alu", fl8(0, 0, 0, 0, 0, 1), 1'b1, 0, 0);
        for (int i = 0; i < 3; i++) cyc_f('0, "fw_idle", c_z, 1'b1, 0, 0);

        // Two writers of R2 in flight: the youngest wins, then older stages.
        cyc_f(mk(1, 0, 0, 0, 0, 2, 1, 0, 0), "yw_old", c_z, 1'b1, 0, 0);
        cyc_f(mk(1, 0, 0, 0, 0, 2, 1, 0, 0), "yw_new", c_z, 1'b1, 0, 0);
        cyc_f(mk(1, 2, 0, 2, 1, 0, 0, 0, 0), "yw_young", fl8(0, 0, 0, 0, 0, 1), 1'b1, 0, 0);
        cyc_f(mk(1, 0, 0, 2, 1, 0, 0, 0, 0), "yw_stage2", fl8(0, 0, 0, 0, 0, 2), 1'b1, 0, 0);
        cyc_f(mk(1, 0, 0, 2, 1, 0, 0, 0, 0), "yw_stage3", fl8(0, 0, 0, 0, 0, 3), 1'b1, 0, 0);
        for (int i = 0; i < 3; i++) cyc_f('0, "yw_idle", c_z, 1'b1, 0, 0);

        // Load-use: one stall cycle, then forward from stage 2.
        cyc_f(mk(1, 0, 0, 0, 0, 5, 1, 1, 0), "lu_load", c_z, 1'b1, 0, 0);
        cyc_f(mk(1, 5, 1, 0, 0, 10, 0, 0, 0), "lu_stall", fl8(1, 1, 0, 1, 1, 0), 1'b1, 0, 0);
        cyc_f(mk(1, 5, 1, 0, 0, 10, 0, 0, 0), "lu_fwd", fl8(0, 0, 0, 0, 2, 0), 1'b1, 1, 0);
        cyc_f('0, "lu_idle", c_z, 1'b1, 1, 0);

        // Asynchronous reset in the middle of a stall.
        cyc_s(mk(1, 0, 0, 0, 0, 1, 1, 0, 0), "mr_prod", c_z, 1'b1, 15, 1);
        cyc_s(mk(1, 1, 1, 0, 0, 0, 0, 0, 0), "mr_stall", c_stal, 1'b1, 15, 1);
        rst = 1'b0;
        #1;
        push(1'b0, "mr_reset_s", c_z, 1'b1, 0, 0);
        push(1'b1, "mr_reset_f", c_z, 1'b1, 0, 0);
        tick();
        rst  = 1'b1;
        in_s = '0;
        push(1'b0, "mr_release_s", c_z, 1'b1, 0, 0);
        push(1'b1, "mr_release_f", c_z, 1'b1, 0, 0);
        tick();

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
